// File: rtl/spi_reg_pkg.sv
// Shared types and defaults for the SPI register command sequencer.
// Holds the FSM state encoding, command layout and default idle byte.
package spi_reg_pkg;

  localparam int BITS_DEF = 8;
  localparam int CMD_RW_BIT = BITS_DEF - 1;
  localparam logic [BITS_DEF-1:0] IDLE_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RFETCH,
    ST_RWAIT,
    ST_RDATA
  } state_t;

  function automatic int addr_w(input int bits);
    return bits - 1;
  endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-side SPI and register-bank signals of the command sequencer.
// slave: the sequencer itself; master: its environment.
interface spi_reg_ctrl_if
  import spi_reg_pkg::*;
#(
  parameter int BITS   = BITS_DEF,
  parameter int ADDR_W = addr_w(BITS)
) ();

  logic              csn;
  logic [BITS-1:0]   rx_data;
  logic              rx_valid;
  logic [BITS-1:0]   tx_data;
  logic [ADDR_W-1:0] reg_addr;
  logic [BITS-1:0]   reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [BITS-1:0]   reg_rdata;
  logic              busy;
  logic              overrun;
  logic              frame_done;

  modport slave (
    input  csn, rx_data, rx_valid, reg_rdata,
    output tx_data, reg_addr, reg_wdata,
    output reg_we, reg_re, busy, overrun, frame_done
  );

  modport master (
    output csn, rx_data, rx_valid, reg_rdata,
    input  tx_data, reg_addr, reg_wdata,
    input  reg_we, reg_re, busy, overrun, frame_done
  );

endinterface

// File: rtl/spi_reg_ctrl_csn_edge.sv
// Chip-select edge detector: remembers the previous csn sample.
// Reset history is 0 so a frame only starts after csn is seen high.
module csn_edge (
  input  logic clk,
  input  logic rstn,
  input  logic i_csn,
  output logic o_cs_start,
  output logic o_cs_end
);

  logic r_csn_d;

  always_ff @(posedge clk) begin
    if (!rstn) r_csn_d <= 1'b0;
    else       r_csn_d <= i_csn;
  end

  assign o_cs_start = r_csn_d & ~i_csn;
  assign o_cs_end   = ~r_csn_d & i_csn;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI frame command sequencer: {rw,addr} command byte then data bytes
// with address auto-increment, driving register-bank strobes.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int BITS   = BITS_DEF,
  parameter int ADDR_W = addr_w(BITS),
  parameter logic [BITS-1:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
  input logic clk,
  input logic rstn,
  spi_reg_ctrl_if.slave bus
);

  state_t r_state, w_next;

  logic              w_cs_start, w_cs_end;
  logic              w_rx;
  logic              w_we, w_re;
  logic              w_addr_ld;
  logic [ADDR_W-1:0] w_addr_val, w_raddr;
  logic              w_ovr_set, w_ovr_clr, w_seen;

  logic [ADDR_W-1:0] r_addr, r_reg_addr;
  logic [BITS-1:0]   r_tx, r_wdata;
  logic              r_we, r_re, r_ovr, r_fd, r_seen;

  csn_edge u_csn_edge (
    .clk        (clk),
    .rstn       (rstn),
    .i_csn      (bus.csn),
    .o_cs_start (w_cs_start),
    .o_cs_end   (w_cs_end)
  );

  // a byte arriving with csn already high is dropped with the frame
  assign w_rx = bus.rx_valid & ~bus.csn;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_we       = 1'b0;
    w_re       = 1'b0;
    w_addr_ld  = 1'b0;
    w_addr_val = r_addr;
    w_raddr    = r_addr;
    w_ovr_set  = 1'b0;
    w_ovr_clr  = 1'b0;
    w_seen     = 1'b0;
    unique case (r_state)
      ST_IDLE: if (w_cs_start) w_next = ST_CMD;
      ST_CMD: if (w_rx) begin
        w_ovr_clr  = 1'b1;
        w_addr_ld  = 1'b1;
        w_addr_val = bus.rx_data[ADDR_W-1:0];
        w_raddr    = bus.rx_data[ADDR_W-1:0];
        if (bus.rx_data[CMD_RW_BIT]) begin
          w_next = ST_RFETCH;
          w_re   = 1'b1;
        end else begin
          w_next = ST_WDATA;
        end
      end
      ST_WDATA: if (w_rx) begin
        w_we       = 1'b1;
        w_seen     = 1'b1;
        w_addr_ld  = 1'b1;
        w_addr_val = r_addr + ADDR_W'(1);
      end
      ST_RFETCH: begin
        w_next    = ST_RWAIT;
        w_ovr_set = w_rx;
      end
      ST_RWAIT: begin
        w_next    = ST_RDATA;
        w_ovr_set = w_rx;
      end
      ST_RDATA: if (w_rx) begin
        w_next     = ST_RFETCH;
        w_re       = 1'b1;
        w_seen     = 1'b1;
        w_addr_ld  = 1'b1;
        w_addr_val = r_addr + ADDR_W'(1);
        w_raddr    = r_addr + ADDR_W'(1);
      end
      default: w_next = ST_IDLE;
    endcase
    if (r_state != ST_IDLE && bus.csn) w_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_addr     <= '0;
      r_reg_addr <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_ovr      <= 1'b0;
      r_fd       <= 1'b0;
      r_seen     <= 1'b0;
      r_tx       <= IDLE_BYTE;
    end else begin
      r_we <= w_we;
      r_re <= w_re;
      r_fd <= w_cs_end & r_seen & (r_state != ST_IDLE);
      if (w_addr_ld) r_addr <= w_addr_val;
      if (w_we | w_re) r_reg_addr <= w_raddr;
      if (w_we) r_wdata <= bus.rx_data;
      if (w_ovr_clr) r_ovr <= 1'b0;
      else if (w_ovr_set) r_ovr <= 1'b1;
      if (r_state == ST_IDLE) r_seen <= 1'b0;
      else if (w_seen) r_seen <= 1'b1;
      if (w_next == ST_IDLE) r_tx <= IDLE_BYTE;
      else if (r_state == ST_RWAIT) r_tx <= bus.reg_rdata;
    end
  end

  assign bus.tx_data    = r_tx;
  assign bus.reg_addr   = r_reg_addr;
  assign bus.reg_wdata  = r_wdata;
  assign bus.reg_we     = r_we;
  assign bus.reg_re     = r_re;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.overrun    = r_ovr;
  assign bus.frame_done = r_fd;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl with a small register-bank read model.
// Frames: write burst, read burst, wrap, aborts, overrun, reset mid-read.
module tb_spi_reg_ctrl;

  logic clk;
  logic rstn;
  int   total;
  int   bad;
  int   we_cnt;
  int   re_cnt;
  int   fd_cnt;
  int   both_cnt;
  logic [7:0] bank [128];

  spi_reg_ctrl_if #(.BITS(8), .ADDR_W(7)) bus ();

  spi_reg_ctrl dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.reg_re) bus.reg_rdata <= bank[bus.reg_addr];
  end

  initial begin
    we_cnt = 0;
    re_cnt = 0;
    fd_cnt = 0;
    both_cnt = 0;
  end

  always @(posedge clk) begin
    if (rstn) begin
      if (bus.reg_we) we_cnt <= we_cnt + 1;
      if (bus.reg_re) re_cnt <= re_cnt + 1;
      if (bus.frame_done) fd_cnt <= fd_cnt + 1;
      if (bus.reg_we && bus.reg_re) both_cnt <= both_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < 128; i++) bank[i] = 8'h00;
    bank[16] = 8'h3C;
    bank[17] = 8'h4D;
    rstn = 1'b0;
    bus.csn = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    tick();
    tick();
    chk("rst_tx", 32'(bus.tx_data), 32'hA5);
    chk("rst_addr", 32'(bus.reg_addr), 32'h0);
    chk("rst_wdata", 32'(bus.reg_wdata), 32'h0);
    chk("rst_we", 32'(bus.reg_we), 32'h0);
    chk("rst_re", 32'(bus.reg_re), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_ovr", 32'(bus.overrun), 32'h0);
    chk("rst_fd", 32'(bus.frame_done), 32'h0);
    rstn = 1'b1;
    tick();

    // write burst 0x05: 0x11, 0x22
    bus.csn = 1'b0;
    tick();
    chk("wr_busy", 32'(bus.busy), 32'h1);
    send(8'h05);
    chk("wr_cmd_nowe", 32'(bus.reg_we), 32'h0);
    tick();
    send(8'h11);
    chk("wr0_we", 32'(bus.reg_we), 32'h1);
    chk("wr0_addr", 32'(bus.reg_addr), 32'h05);
    chk("wr0_data", 32'(bus.reg_wdata), 32'h11);
    tick();
    chk("wr_we_pulse", 32'(bus.reg_we), 32'h0);
    send(8'h22);
    chk("wr1_we", 32'(bus.reg_we), 32'h1);
    chk("wr1_addr", 32'(bus.reg_addr), 32'h06);
    chk("wr1_data", 32'(bus.reg_wdata), 32'h22);
    bus.csn = 1'b1;
    tick();
    chk("wr_fd", 32'(bus.frame_done), 32'h1);
    chk("wr_idle", 32'(bus.busy), 32'h0);
    tick();
    chk("wr_fd_pulse", 32'(bus.frame_done), 32'h0);
    chk("wr_fd_cnt", 32'(fd_cnt), 32'd1);
    chk("wr_we_cnt", 32'(we_cnt), 32'd2);

    // read burst from 0x10
    bus.csn = 1'b0;
    tick();
    send(8'h90);
    chk("rd0_re", 32'(bus.reg_re), 32'h1);
    chk("rd0_addr", 32'(bus.reg_addr), 32'h10);
    chk("rd0_tx_idle", 32'(bus.tx_data), 32'hA5);
    tick();
    chk("rd0_re_pulse", 32'(bus.reg_re), 32'h0);
    tick();
    chk("rd0_tx", 32'(bus.tx_data), 32'h3C);
    tick();
    chk("rd0_tx_hold", 32'(bus.tx_data), 32'h3C);
    send(8'h00);
    chk("rd1_re", 32'(bus.reg_re), 32'h1);
    chk("rd1_addr", 32'(bus.reg_addr), 32'h11);
    chk("rd1_tx_old", 32'(bus.tx_data), 32'h3C);
    tick();
    tick();
    chk("rd1_tx", 32'(bus.tx_data), 32'h4D);
    send(8'h00);
    chk("rd2_addr", 32'(bus.reg_addr), 32'h12);
    bus.csn = 1'b1;
    tick();
    chk("rd_fd", 32'(bus.frame_done), 32'h1);
    chk("rd_tx_idle", 32'(bus.tx_data), 32'hA5);
    tick();
    chk("rd_re_cnt", 32'(re_cnt), 32'd3);

    // write wrapping 0x7F -> 0x00
    bus.csn = 1'b0;
    tick();
    send(8'h7F);
    send(8'hAA);
    chk("wrap0_addr", 32'(bus.reg_addr), 32'h7F);
    chk("wrap0_data", 32'(bus.reg_wdata), 32'hAA);
    send(8'hBB);
    chk("wrap1_addr", 32'(bus.reg_addr), 32'h00);
    chk("wrap1_data", 32'(bus.reg_wdata), 32'hBB);
    bus.csn = 1'b1;
    tick();
    chk("wrap_fd", 32'(bus.frame_done), 32'h1);
    tick();

    // abort right after a write command
    bus.csn = 1'b0;
    tick();
    send(8'h03);
    bus.csn = 1'b1;
    tick();
    chk("abort_fd", 32'(bus.frame_done), 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_tx", 32'(bus.tx_data), 32'hA5);
    tick();

    // data byte coinciding with csn rising is dropped
    bus.csn = 1'b0;
    tick();
    send(8'h20);
    bus.csn = 1'b1;
    send(8'h77);
    chk("race_we", 32'(bus.reg_we), 32'h0);
    chk("race_fd", 32'(bus.frame_done), 32'h0);
    tick();
    chk("race_we_cnt", 32'(we_cnt), 32'd4);

    // overrun during prefetch
    bus.csn = 1'b0;
    tick();
    send(8'h90);
    send(8'h55);
    chk("ovr_set", 32'(bus.overrun), 32'h1);
    chk("ovr_we", 32'(bus.reg_we), 32'h0);
    chk("ovr_re", 32'(bus.reg_re), 32'h0);
    tick();
    chk("ovr_tx", 32'(bus.tx_data), 32'h3C);
    bus.csn = 1'b1;
    tick();
    chk("ovr_fd", 32'(bus.frame_done), 32'h0);
    chk("ovr_sticky", 32'(bus.overrun), 32'h1);
    bus.csn = 1'b0;
    tick();
    chk("ovr_hold", 32'(bus.overrun), 32'h1);
    send(8'h01);
    chk("ovr_clr", 32'(bus.overrun), 32'h0);
    bus.csn = 1'b1;
    tick();
    tick();

    // reset while waiting for read data
    bus.csn = 1'b0;
    tick();
    send(8'h91);
    chk("rst_rd_re", 32'(bus.reg_re), 32'h1);
    tick();
    rstn = 1'b0;
    tick();
    chk("mid_tx", 32'(bus.tx_data), 32'hA5);
    chk("mid_addr", 32'(bus.reg_addr), 32'h0);
    chk("mid_re", 32'(bus.reg_re), 32'h0);
    chk("mid_we", 32'(bus.reg_we), 32'h0);
    chk("mid_busy", 32'(bus.busy), 32'h0);
    chk("mid_ovr", 32'(bus.overrun), 32'h0);
    chk("mid_fd", 32'(bus.frame_done), 32'h0);
    rstn = 1'b1;
    tick();
    tick();
    tick();
    chk("post_busy", 32'(bus.busy), 32'h0);
    chk("post_re_cnt", 32'(re_cnt), 32'd5);
    chk("post_we_cnt", 32'(we_cnt), 32'd4);
    chk("post_fd_cnt", 32'(fd_cnt), 32'd3);
    chk("never_both", 32'(both_cnt), 32'd0);
    bus.csn = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
